// File: rtl/slot_arbiter.sv
// Round-robin arbiter that shares one 32-bit Hedios slot word between several
// requesters, publishing {sequence, requester id, data} once per tenure.
module slot_arbiter #(
  parameter int REQ_COUNT   = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                        slower_clock,
  input  logic                        rst,
  input  logic [REQ_COUNT-1:0]        req,
  input  logic [REQ_COUNT*DATA_W-1:0] req_data,
  output logic [REQ_COUNT-1:0]        grant,
  output logic [31:0]                 slot_word,
  output logic                        slot_valid,
  output logic                        busy
);

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [HC_W-1:0]   hold_cnt;
  logic [7:0]        seq;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic [DATA_W-1:0] win_data;
  logic [7:0]        seq_next;
  logic              tenure_end;
  logic              arbitrate;

  // Scan starts just past the previous owner, so the owner itself comes last
  // and only keeps the slot when nobody else is asking.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      cand = IDX_W'((int'(last) + k) % REQ_COUNT);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_data   = req_data[int'(win_idx)*DATA_W +: DATA_W];
  assign seq_next   = seq + 8'd1;
  assign tenure_end = (state == OWN) &&
                      (!req[last] || (hold_cnt == HC_W'(HOLD_CYCLES - 1)));
  assign arbitrate  = (state == IDLE) || tenure_end;
  assign busy       = |grant;

  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last       <= IDX_W'(REQ_COUNT - 1);
      hold_cnt   <= '0;
      seq        <= 8'd0;
      slot_word  <= 32'd0;
      slot_valid <= 1'b0;
    end else begin
      slot_valid <= 1'b0;
      if (arbitrate) begin
        if (win_found) begin
          state      <= OWN;
          grant      <= REQ_COUNT'(1) << win_idx;
          last       <= win_idx;
          hold_cnt   <= '0;
          seq        <= seq_next;
          slot_word  <= {seq_next, 8'(win_idx), 16'(win_data)};
          slot_valid <= 1'b1;
        end else begin
          state <= IDLE;
          grant <= '0;
        end
      end else if (state == OWN) begin
        hold_cnt <= hold_cnt + HC_W'(1);
      end
    end
  end

endmodule
